// File: rtl/divider_scheduler_if.sv
// Config/control handshake and status bus for divider_scheduler.
interface divider_scheduler_if #(
  parameter int unsigned W = 26
);
  logic         cfg_valid;
  logic         cfg_ready;
  logic [W-1:0] cfg_div;
  logic [15:0]  cfg_count;
  logic         start;
  logic         stop;
  logic         tick;
  logic         clk_out;
  logic         busy;
  logic         done;
  logic         cfg_err;

  modport master (
    output cfg_valid, cfg_div, cfg_count, start, stop,
    input  cfg_ready, tick, clk_out, busy, done, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_div, cfg_count, start, stop,
    output cfg_ready, tick, clk_out, busy, done, cfg_err
  );
endinterface

// File: rtl/divider_scheduler.sv
// Programmable clock divider with counted/free-running runs and a
// one-deep pending config slot applied on period boundaries.
module divider_scheduler #(
  parameter int unsigned W           = 26,
  parameter int unsigned DEFAULT_DIV = 25_000_000
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  divider_scheduler_if.slave    bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] div_q, div_d;
  logic [15:0]  cnt_q, cnt_d;
  logic [W-1:0] dc_q, dc_d;
  logic [15:0]  tr_q, tr_d;
  logic         pend_v_q, pend_v_d;
  logic [W-1:0] pend_div_q, pend_div_d;
  logic [15:0]  pend_cnt_q, pend_cnt_d;
  logic         clk_out_q, clk_out_d;
  logic         done_q, done_d;
  logic         cfg_err_q, cfg_err_d;

  logic         hs;
  logic         cfg_bad;
  logic         tick;

  // Handshake decode and period-end detection.
  always_comb begin
    hs      = bus.cfg_valid && !pend_v_q;
    cfg_bad = bus.cfg_div < W'(2);
    tick    = (state_q == RUN) && (dc_q == div_q - W'(1));
  end

  // Next-state, counters, config slot and registered pulse outputs.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    cnt_d      = cnt_q;
    dc_d       = dc_q;
    tr_d       = tr_q;
    pend_v_d   = pend_v_q;
    pend_div_d = pend_div_q;
    pend_cnt_d = pend_cnt_q;
    done_d     = 1'b0;
    cfg_err_d  = hs && cfg_bad;
    clk_out_d  = (state_q == RUN) && (dc_q >= (div_q >> 1));

    // hs implies pend_v_q == 0, so this never collides with a slot apply below.
    if (hs && !cfg_bad) begin
      if (state_q == IDLE) begin
        div_d = bus.cfg_div;
        cnt_d = bus.cfg_count;
      end else begin
        pend_v_d   = 1'b1;
        pend_div_d = bus.cfg_div;
        pend_cnt_d = bus.cfg_count;
      end
    end

    case (state_q)
      IDLE: begin
        if (pend_v_q) begin
          div_d    = pend_div_q;
          cnt_d    = pend_cnt_q;
          pend_v_d = 1'b0;
        end
        if (bus.start && !bus.stop) begin
          state_d = RUN;
          dc_d    = '0;
          tr_d    = cnt_q;
        end
      end
      RUN: begin
        dc_d = tick ? '0 : dc_q + W'(1);
        if (tick) begin
          if (pend_v_q) begin
            div_d    = pend_div_q;
            cnt_d    = pend_cnt_q;
            pend_v_d = 1'b0;
          end
          if (cnt_q != '0) begin
            tr_d = tr_q - 16'd1;
            if (tr_q == 16'd1) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
        // Stop overrides a simultaneous final tick; done still pulses once.
        if (bus.stop) begin
          state_d = IDLE;
          dc_d    = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      div_q      <= W'(DEFAULT_DIV);
      cnt_q      <= '0;
      dc_q       <= '0;
      tr_q       <= '0;
      pend_v_q   <= 1'b0;
      pend_div_q <= '0;
      pend_cnt_q <= '0;
      clk_out_q  <= 1'b0;
      done_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      dc_q       <= dc_d;
      tr_q       <= tr_d;
      pend_v_q   <= pend_v_d;
      pend_div_q <= pend_div_d;
      pend_cnt_q <= pend_cnt_d;
      clk_out_q  <= clk_out_d;
      done_q     <= done_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign bus.cfg_ready = !pend_v_q;
  assign bus.tick      = tick;
  assign bus.clk_out   = clk_out_q;
  assign bus.busy      = (state_q == RUN);
  assign bus.done      = done_q;
  assign bus.cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_divider_scheduler.sv
// Directed self-checking bench for divider_scheduler (small W and default divisor).
module tb_divider_scheduler;
  localparam int unsigned W   = 8;
  localparam int unsigned DEF = 6;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;
  int   checks = 0;
  int   errors = 0;

  divider_scheduler_if #(.W(W)) bus ();

  divider_scheduler #(.W(W), .DEFAULT_DIV(DEF)) dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic configure(input logic [W-1:0] d, input logic [15:0] n);
    bus.cfg_valid = 1'b1;
    bus.cfg_div   = d;
    bus.cfg_count = n;
    step();
    bus.cfg_valid = 1'b0;
  endtask

  // After return the bench sits in cycle 1 of the run (dc == 0).
  task automatic start_run();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    logic [5:0] obs, exp;
    rst_n = 1'b0;
    step();
    step();
    obs = {bus.busy, bus.done, bus.cfg_ready, bus.tick, bus.clk_out, bus.cfg_err};
    exp = 6'b001000;
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL reset_state busy/done/rdy/tick/clk/err got %b want %b", obs, exp);
    end
    rst_n = 1'b1;
    // Default divisor with cnt_r = 0: free-run with period DEF.
    start_run();
    for (int c = 1; c <= 13; c++) begin
      exp = {4'b0000, (c == 6 || c == 12), 1'b1};
      obs = {4'b0000, bus.tick, bus.busy};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL reset_default_div cycle %0d tick/busy got %b want %b", c, obs[1:0], exp[1:0]);
      end
      step();
    end
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    obs = {4'b0000, bus.busy, bus.done};
    checks++;
    if (obs !== 6'b000001) begin
      errors++;
      $display("FAIL reset_default_stop busy/done got %b want 01", obs[1:0]);
    end
    step();
  endtask

  task automatic test_basic();
    logic [3:0] obs, exp;
    configure(8'd4, 16'd3);
    start_run();
    for (int c = 1; c <= 14; c++) begin
      exp = {(c inside {4, 8, 12}), (c == 13), (c <= 12), (c inside {4, 5, 8, 9, 12, 13})};
      obs = {bus.tick, bus.done, bus.busy, bus.clk_out};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL basic_run cycle %0d tick/done/busy/clk got %b want %b", c, obs, exp);
      end
      // Start mid-run must be ignored.
      bus.start = (c == 6);
      step();
    end
    bus.start = 1'b0;
  endtask

  task automatic test_cfg_err();
    logic [2:0] obs, exp;
    configure(8'd1, 16'd2);
    obs = {bus.cfg_err, bus.cfg_ready, bus.busy};
    checks++;
    if (obs !== 3'b110) begin
      errors++;
      $display("FAIL cfg_err_pulse err/rdy/busy got %b want 110", obs);
    end
    step();
    checks++;
    if (bus.cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL cfg_err_once got %b want 0", bus.cfg_err);
    end
    start_run();
    for (int c = 1; c <= 14; c++) begin
      exp = {(c inside {4, 8, 12}), (c == 13), (c <= 12)};
      obs = {bus.tick, bus.done, bus.busy};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL cfg_err_kept_div cycle %0d tick/done/busy got %b want %b", c, obs, exp);
      end
      step();
    end
  endtask

  task automatic test_free_run();
    logic [3:0] obs, exp;
    configure(8'd5, 16'd0);
    bus.cfg_div   = 8'd8;
    bus.cfg_count = 16'd0;
    start_run();
    for (int c = 1; c <= 27; c++) begin
      exp = {(c inside {5, 10, 18, 26}), !(c >= 8 && c <= 10), 1'b1, 1'b0};
      obs = {bus.tick, bus.cfg_ready, bus.busy, bus.done};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL free_run cycle %0d tick/rdy/busy/done got %b want %b", c, obs, exp);
      end
      bus.cfg_valid = (c == 7);
      step();
    end
    bus.cfg_valid = 1'b0;
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    obs = {bus.busy, bus.done, bus.tick, 1'b0};
    checks++;
    if (obs !== 4'b0100) begin
      errors++;
      $display("FAIL free_run_stop busy/done/tick got %b want 010", obs[3:1]);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [1:0] obs, exp;
    configure(8'd4, 16'd0);
    bus.cfg_div   = 8'd3;
    bus.cfg_count = 16'd0;
    start_run();
    for (int c = 1; c <= 15; c++) begin
      exp = {(c inside {4, 8, 11, 14}), !(c >= 5 && c <= 8)};
      obs = {bus.tick, bus.cfg_ready};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL cfg_on_tick cycle %0d tick/rdy got %b want %b", c, obs, exp);
      end
      bus.cfg_valid = (c == 4);
      step();
    end
    bus.cfg_valid = 1'b0;
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    obs = {bus.busy, bus.done};
    checks++;
    if (obs !== 2'b01) begin
      errors++;
      $display("FAIL cfg_on_tick_stop busy/done got %b want 01", obs);
    end
    step();
  endtask

  task automatic test_start_stop();
    logic [2:0] obs;
    int         done_cnt;
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    step();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      obs = {bus.busy, bus.tick, bus.done};
      checks++;
      if (obs !== 3'b000) begin
        errors++;
        $display("FAIL start_stop_idle cycle %0d busy/tick/done got %b want 000", c, obs);
      end
      step();
    end
    configure(8'd4, 16'd0);
    start_run();
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if (bus.tick !== (c == 4)) begin
        errors++;
        $display("FAIL stop_on_tick cycle %0d tick got %b want %b", c, bus.tick, (c == 4));
      end
      bus.stop = (c == 4);
      step();
    end
    bus.stop = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      if (bus.done === 1'b1) done_cnt++;
      checks++;
      if (bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL stop_on_tick_idle cycle %0d busy got %b want 0", c, bus.busy);
      end
      step();
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL stop_on_tick_done_count got %0d want 1", done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0] obs;
    configure(8'd4, 16'd0);
    bus.cfg_div   = 8'd7;
    bus.cfg_count = 16'd0;
    start_run();
    bus.cfg_valid = 1'b1;
    step();
    bus.cfg_valid = 1'b0;
    checks++;
    if (bus.cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_pending rdy got %b want 0", bus.cfg_ready);
    end
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    obs = {bus.busy, bus.done, bus.cfg_ready, bus.tick, bus.clk_out};
    checks++;
    if (obs !== 5'b00100) begin
      errors++;
      $display("FAIL reset_mid_state busy/done/rdy/tick/clk got %b want 00100", obs);
    end
    step();
    obs = {bus.busy, bus.done, bus.cfg_ready, 2'b00};
    checks++;
    if (obs !== 5'b00100) begin
      errors++;
      $display("FAIL reset_mid_after busy/done/rdy got %b want 001", obs[4:2]);
    end
    // Default divisor must be back and the discarded pending word not applied.
    start_run();
    for (int c = 1; c <= 12; c++) begin
      checks++;
      if (bus.tick !== (c == 6 || c == 12)) begin
        errors++;
        $display("FAIL reset_mid_period cycle %0d tick got %b want %b", c, bus.tick, (c == 6 || c == 12));
      end
      step();
    end
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    step();
  endtask

  initial begin
    bus.cfg_valid = 1'b0;
    bus.cfg_div   = '0;
    bus.cfg_count = '0;
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    test_reset();
    test_basic();
    test_cfg_err();
    test_free_run();
    test_back_to_back();
    test_start_stop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
